voice_amp_scheduler: RTL and testbench

//   Time-multiplexes one signed-by-unsigned amplitude multiplier across NUM_VOICES voices.
//   On each sample tick it snapshots every voice sample and its envelope amplitude.
//   It scales each voice in turn, accumulates the results and emits one saturated mix sample.

---
 rtl/voice_amp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_voice_amp_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_amp_scheduler.sv
// Time-multiplexed voice amplitude scaler and mixer: one multiplier, NUM_VOICES voices per sample tick.
// Optional feature: define VOICE_MUTE_EN to add a per-voice mute input snapshotted at the tick.
module voice_amp_scheduler #(
    parameter int unsigned DATA_BITS      = 12,
    parameter int unsigned AMPLITUDE_BITS = 8,
    parameter int unsigned NUM_VOICES     = 4,
    parameter int unsigned VOICE_SEL_BITS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_tick,
    input  logic [NUM_VOICES*DATA_BITS-1:0]      voice_din,
    input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] voice_amp,
`ifdef VOICE_MUTE_EN
    input  logic [NUM_VOICES-1:0]                voice_mute,
`endif
    output logic [DATA_BITS-1:0]                 mix_out,
    output logic                                 mix_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int unsigned PROD_W = DATA_BITS + AMPLITUDE_BITS;
    localparam int unsigned ACC_W  = DATA_BITS + VOICE_SEL_BITS;
    localparam logic [DATA_BITS-1:0]    MID    = {1'b1, {(DATA_BITS-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'((2 ** (DATA_BITS-1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_LO = ~ACC_HI;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic                                w_load;
    logic                                w_issue;
    logic                                w_last;

    logic [NUM_VOICES*DATA_BITS-1:0]      r_din;
    logic [NUM_VOICES*AMPLITUDE_BITS-1:0] r_amp;
    logic [VOICE_SEL_BITS-1:0]            r_idx;
    logic signed [DATA_BITS-1:0]          r_prod;
    logic                                 r_prod_vld;
    logic signed [ACC_W-1:0]              r_acc;
    logic [DATA_BITS-1:0]                 r_mix_out;
    logic                                 r_mix_valid;
    logic                                 r_busy;
    logic                                 r_overrun;

    logic signed [DATA_BITS-1:0]          w_s;
    logic signed [AMPLITUDE_BITS:0]       w_a;
    logic signed [PROD_W-1:0]             w_prod;
    logic signed [DATA_BITS-1:0]          w_scaled;
    logic                                 w_mute_sel;
    logic signed [ACC_W-1:0]              w_acc_next;
    logic signed [DATA_BITS-1:0]          w_sat;

`ifdef VOICE_MUTE_EN
    logic [NUM_VOICES-1:0]                r_mute;
    assign w_mute_sel = r_mute[r_idx];
`else
    assign w_mute_sel = 1'b0;
`endif

    // Selected voice, converted from offset-binary and scaled by its amplitude
    assign w_s      = r_din[r_idx*DATA_BITS +: DATA_BITS] ^ MID;
    assign w_a      = {1'b0, r_amp[r_idx*AMPLITUDE_BITS +: AMPLITUDE_BITS]};
    assign w_prod   = PROD_W'(w_s) * PROD_W'(w_a);
    assign w_scaled = DATA_BITS'(w_prod >>> AMPLITUDE_BITS);
    assign w_last   = (r_idx == VOICE_SEL_BITS'(NUM_VOICES - 1));

    assign w_acc_next = r_prod_vld ? (r_acc + ACC_W'(r_prod)) : r_acc;

    always_comb begin
        w_sat = w_acc_next[DATA_BITS-1:0];
        if (w_acc_next > ACC_HI) begin
            w_sat = DATA_BITS'(ACC_HI);
        end else if (w_acc_next < ACC_LO) begin
            w_sat = DATA_BITS'(ACC_LO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                w_issue = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, issue/accumulate pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din       <= '0;
            r_amp       <= '0;
            r_idx       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_mix_out   <= MID;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mix_valid <= (r_state == S_DRAIN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_prod_vld  <= w_issue;
            if (sample_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_load) begin
                r_din <= voice_din;
                r_amp <= voice_amp;
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
            if (w_issue) begin
                r_prod <= w_mute_sel ? '0 : w_scaled;
                r_idx  <= r_idx + VOICE_SEL_BITS'(1);
            end
            if (r_state == S_DRAIN) begin
                r_mix_out <= w_sat ^ MID;
            end
        end
    end

`ifdef VOICE_MUTE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mute <= '0;
        end else if (w_load) begin
            r_mute <= voice_mute;
        end
    end
`endif

    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_voice_amp_scheduler.sv
// Self-checking bench for voice_amp_scheduler: vector table, corner sequences and random traffic.
module tb_voice_amp_scheduler;

    localparam int unsigned DB = 12;
    localparam int unsigned AB = 8;
    localparam int unsigned NV = 4;
    localparam int unsigned SB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_tick;
    logic [NV*DB-1:0]  voice_din;
    logic [NV*AB-1:0]  voice_amp;
`ifdef VOICE_MUTE_EN
    logic [NV-1:0]     voice_mute;
`endif
    logic [DB-1:0]     mix_out;
    logic              mix_valid;
    logic              busy;
    logic              overrun;

    voice_amp_scheduler #(
        .DATA_BITS(DB), .AMPLITUDE_BITS(AB), .NUM_VOICES(NV), .VOICE_SEL_BITS(SB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_tick(sample_tick),
        .voice_din(voice_din),
        .voice_amp(voice_amp),
`ifdef VOICE_MUTE_EN
        .voice_mute(voice_mute),
`endif
        .mix_out(mix_out),
        .mix_valid(mix_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV*DB-1:0] din;
        logic [NV*AB-1:0] amp;
        logic [NV-1:0]    mute;
        logic [DB-1:0]    exp_mix;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Frame-level reference: remaining busy cycles, held mix, pending result, sticky overrun
    int            m_left = 0;
    logic [DB-1:0] m_mix  = 12'h800;
    logic [DB-1:0] m_pend = 12'h800;
    logic          m_ovr  = 1'b0;

    function automatic logic [DB-1:0] ref_mix(input logic [NV*DB-1:0] din,
                                              input logic [NV*AB-1:0] amp,
                                              input logic [NV-1:0]    mute);
        int            sum;
        logic [DB-1:0] res;
        sum = 0;
        for (int v = 0; v < int'(NV); v++) begin
            int s;
            int a;
            s = int'(din[v*DB +: DB]) - 2048;
            a = int'(amp[v*AB +: AB]);
            if (!mute[v]) sum += (s * a) >>> AB;
        end
        if (sum > 2047)  sum = 2047;
        if (sum < -2048) sum = -2048;
        res = DB'(sum);
        return res ^ 12'h800;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive tick/rst, advance, update the reference, compare all outputs
    task automatic cycle(input logic tick, input logic r);
        logic [NV*DB-1:0] s_din;
        logic [NV*AB-1:0] s_amp;
        logic [NV-1:0]    s_mute;
        sample_tick = tick;
        rst         = r;
        s_din       = voice_din;
        s_amp       = voice_amp;
`ifdef VOICE_MUTE_EN
        s_mute      = voice_mute;
`else
        s_mute      = '0;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            m_left = 0;
            m_mix  = 12'h800;
            m_ovr  = 1'b0;
        end else if (m_left > 0) begin
            if (tick) m_ovr = 1'b1;
            m_left--;
            if (m_left == 1) m_mix = m_pend;
        end else if (tick) begin
            m_left = int'(NV) + 2;
            m_pend = ref_mix(s_din, s_amp, s_mute);
        end
        check("mix_out",   int'(mix_out),   int'(m_mix));
        check("mix_valid", int'(mix_valid), (m_left == 1) ? 1 : 0);
        check("busy",      int'(busy),      (m_left > 0) ? 1 : 0);
        check("overrun",   int'(overrun),   int'(m_ovr));
    endtask

    task automatic add_vec(input logic [NV*DB-1:0] din, input logic [NV*AB-1:0] amp,
                           input logic [NV-1:0] mute, input logic [DB-1:0] exp_mix);
        vec_t v;
        v.din     = din;
        v.amp     = amp;
        v.mute    = mute;
        v.exp_mix = exp_mix;
        vecs.push_back(v);
    endtask

    task automatic drive_vec(input vec_t v);
        voice_din = v.din;
        voice_amp = v.amp;
`ifdef VOICE_MUTE_EN
        voice_mute = v.mute;
`endif
    endtask

    task automatic scramble_inputs();
        for (int v = 0; v < int'(NV); v++) begin
            voice_din[v*DB +: DB] = DB'($urandom);
            voice_amp[v*AB +: AB] = AB'($urandom);
        end
`ifdef VOICE_MUTE_EN
        voice_mute = NV'($urandom);
`endif
    endtask

    initial begin
        add_vec({4{12'hFFF}}, {4{8'hFF}}, 4'b0000, 12'hFFF);
        add_vec({12'h123, 12'h123, 12'h123, 12'h000}, {8'h00, 8'h00, 8'h00, 8'h80}, 4'b0000, 12'h400);
        add_vec({12'h123, 12'h456, 12'h789, 12'h000}, {4{8'h00}}, 4'b0000, 12'h800);
        add_vec({4{12'h000}}, {4{8'hFF}}, 4'b0000, 12'h000);
        add_vec({12'h800, 12'h800, 12'h900, 12'hC00}, {8'h00, 8'h00, 8'h40, 8'h80}, 4'b0000, 12'hA40);
        add_vec({12'h800, 12'h800, 12'h800, 12'h7FF}, {8'h00, 8'h00, 8'h00, 8'h01}, 4'b0000, 12'h7FF);
        add_vec({4{12'hFFF}}, {8'h00, 8'h00, 8'h80, 8'h80}, 4'b0000, 12'hFFE);
`ifdef VOICE_MUTE_EN
        add_vec({4{12'hFFF}}, {4{8'hFF}}, 4'b1110, 12'hFF7);
`endif

        sample_tick = 1'b0;
        rst         = 1'b1;
        voice_din   = '0;
        voice_amp   = '0;
`ifdef VOICE_MUTE_EN
        voice_mute  = '0;
`endif

        // Reset for two cycles
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check("rst_mix_out", int'(mix_out), 'h800);
        check("rst_busy", int'(busy), 0);

        // Vector table: inputs scrambled after the tick must not matter
        foreach (vecs[i]) begin
            drive_vec(vecs[i]);
            cycle(1'b1, 1'b0);
            for (int k = 0; k < 5; k++) begin
                scramble_inputs();
                cycle(1'b0, 1'b0);
            end
            check($sformatf("vec%0d_valid", i), int'(mix_valid), 1);
            check($sformatf("vec%0d_mix", i), int'(mix_out), int'(vecs[i].exp_mix));
            cycle(1'b0, 1'b0);
        end

        // Second tick during a frame: ignored, overrun set; tick at T+7 accepted
        drive_vec(vecs[1]);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        drive_vec(vecs[0]);
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
        check("ovr_valid", int'(mix_valid), 1);
        check("ovr_mix", int'(mix_out), 'h400);
        check("ovr_flag", int'(overrun), 1);
        cycle(1'b0, 1'b0);
        drive_vec(vecs[3]);
        cycle(1'b1, 1'b0);
        check("ovr_next_busy", int'(busy), 1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);
        check("ovr_next_mix", int'(mix_out), 'h000);
        check("ovr_sticky", int'(overrun), 1);
        cycle(1'b0, 1'b0);

        // Reset mid-frame aborts; a tick at T+5 completes at T+11
        drive_vec(vecs[0]);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("abort_busy", int'(busy), 0);
        check("abort_mix", int'(mix_out), 'h800);
        check("abort_ovr", int'(overrun), 0);
        cycle(1'b0, 1'b0);
        drive_vec(vecs[4]);
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);
        check("abort_next_valid", int'(mix_valid), 1);
        check("abort_next_mix", int'(mix_out), 'hA40);
        cycle(1'b0, 1'b0);

        // Tick coincident with reset is dropped
        cycle(1'b1, 1'b1);
        check("tick_rst_busy", int'(busy), 0);

        // Random traffic against the reference
        for (int n = 0; n < 600; n++) begin
            scramble_inputs();
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
